// File: rtl/linebuf_fifo_ctrl_pkg.sv
// Shared definitions for the 3x3 line-buffer controller.
// Holds FSM state encodings, err bit positions and counter widths.
// No logic; imported by the controller and its window register.
package linebuf_fifo_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ROW0   = 3'd1;
    localparam state_t ST_ROW1   = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;

    localparam int ERR_W    = 2;
    localparam int ERR_OVF  = 0;
    localparam int ERR_PROT = 1;

    // Counters sized for the largest legal image dimension.
    localparam int IMG_DIM_MAX = 1024;
    localparam int CNT_W       = $clog2(IMG_DIM_MAX);

endpackage

// File: rtl/linebuf_fifo_ctrl_win.sv
// 3x3 window shift register: one new column enters at c=2 per shift.
// Latency: window visible the cycle after shift_en.
// No backpressure; shifts whenever shift_en is high.
module conv_win3x3_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_en,
    input  logic [DATA_WIDTH-1:0]   row0_in,
    input  logic [DATA_WIDTH-1:0]   row1_in,
    input  logic [DATA_WIDTH-1:0]   row2_in,
    output logic [9*DATA_WIDTH-1:0] win_data
);
    import linebuf_fifo_ctrl_pkg::*;

    logic [9*DATA_WIDTH-1:0] win_q;
    logic [9*DATA_WIDTH-1:0] win_d;

    // Shift each row one column older and insert the new column at c=2.
    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < 3; r++) begin
                win_d[(r*3+0)*DATA_WIDTH +: DATA_WIDTH] = win_q[(r*3+1)*DATA_WIDTH +: DATA_WIDTH];
                win_d[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[(r*3+2)*DATA_WIDTH +: DATA_WIDTH];
            end
            win_d[2*DATA_WIDTH +: DATA_WIDTH] = row0_in;
            win_d[5*DATA_WIDTH +: DATA_WIDTH] = row1_in;
            win_d[8*DATA_WIDTH +: DATA_WIDTH] = row2_in;
        end
    end

    // Window storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) win_q <= '0;
        else        win_q <= win_d;
    end

    assign win_data = win_q;

endmodule

// File: rtl/linebuf_fifo_ctrl.sv
// Line-buffer controller: steers pixels through two external line FIFOs into a 3x3 window.
// Latency: win_valid/win_data one clk after the accepted pixel; FIFO read data used same cycle.
// No backpressure: in_valid is accepted in ROW0/ROW1/STREAM; full/empty suppress and flag err.
module linebuf_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    f0_wr_en,
    output logic                    f1_wr_en,
    output logic [DATA_WIDTH-1:0]   f0_wr_data,
    output logic [DATA_WIDTH-1:0]   f1_wr_data,
    output logic                    f0_rd_en,
    output logic                    f1_rd_en,
    input  logic [DATA_WIDTH-1:0]   f0_rd_data,
    input  logic [DATA_WIDTH-1:0]   f1_rd_data,
    input  logic                    f0_empty,
    input  logic                    f1_empty,
    input  logic                    f0_full,
    input  logic                    f1_full,
    output logic                    win_valid,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    busy,
    output logic [1:0]              err
);
    import linebuf_fifo_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               win_valid_q, win_valid_d;

    logic               accept, need_pop0, need_pop1, pop0_ok, pop1_ok;
    logic               in_drain, start, col_wrap;
    logic [DATA_WIDTH-1:0] tap0, tap1;

    // Per-pixel datapath decisions: which FIFOs must be popped and the taps they feed.
    always_comb begin
        in_drain  = (state_q == ST_DRAIN);
        start     = frame_start && (state_q == ST_IDLE);
        accept    = in_valid && ((state_q == ST_ROW0) || (state_q == ST_ROW1) ||
                                 (state_q == ST_STREAM));
        need_pop0 = accept && ((state_q == ST_ROW1) || (state_q == ST_STREAM));
        need_pop1 = accept && (state_q == ST_STREAM);
        pop0_ok   = need_pop0 && !f0_empty;
        pop1_ok   = need_pop1 && !f1_empty;
        tap0      = pop0_ok ? f0_rd_data : '0;
        tap1      = pop1_ok ? f1_rd_data : '0;
        col_wrap  = accept && (col_q == COL_LAST);
    end

    // FIFO0 takes the live pixel; FIFO1 takes the word just popped from FIFO0 (zero if starved).
    assign f0_wr_en   = accept && !f0_full;
    assign f1_wr_en   = need_pop0 && !f1_full;
    assign f0_wr_data = in_data;
    assign f1_wr_data = tap0;
    assign f0_rd_en   = pop0_ok || (in_drain && !f0_empty);
    assign f1_rd_en   = pop1_ok || (in_drain && !f1_empty);

    // Next-state, counter and sticky-error logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = accept && (row_q >= TWO) && (col_q >= TWO);

        if (start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:   if (frame_start) state_d = ST_ROW0;
            ST_ROW0:   if (col_wrap) state_d = ST_ROW1;
            ST_ROW1:   if (col_wrap) state_d = ST_STREAM;
            ST_STREAM: if (col_wrap && (row_q == ROW_LAST)) state_d = ST_DRAIN;
            ST_DRAIN:  if (f0_empty && f1_empty) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A new frame clears old flags; anything flagged in the same cycle still sticks.
        err_d = start ? '0 : err_q;
        err_d[ERR_OVF]  = err_d[ERR_OVF] | (accept && f0_full) | (need_pop0 && f1_full);
        err_d[ERR_PROT] = err_d[ERR_PROT]
                        | (need_pop0 && f0_empty) | (need_pop1 && f1_empty)
                        | (in_valid && ((state_q == ST_IDLE) || in_drain))
                        | (frame_start && (state_q != ST_IDLE));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            err_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            err_q       <= err_d;
            win_valid_q <= win_valid_d;
        end
    end

    conv_win3x3_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_win (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .row0_in  (tap1),
        .row1_in  (tap0),
        .row2_in  (in_data),
        .win_data (win_data)
    );

    assign win_valid = win_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_linebuf_fifo_ctrl.sv
// Bench for linebuf_fifo_ctrl with 4x4 frames and behavioural show-ahead line FIFOs.
// Expected windows are queued when pixels are driven and checked when win_valid fires.
// Flag forcing exercises the overflow/underflow paths.
module tb_linebuf_fifo_ctrl;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk, rst_n, frame_start, in_valid;
    logic [DW-1:0] in_data;
    logic          f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en;
    logic [DW-1:0] f0_wr_data, f1_wr_data, f0_rd_data, f1_rd_data;
    logic          f0_empty, f1_empty, f0_full, f1_full;
    logic          win_valid, busy;
    logic [9*DW-1:0] win_data;
    logic [1:0]    err;

    linebuf_fifo_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data),
        .f0_wr_en(f0_wr_en), .f1_wr_en(f1_wr_en),
        .f0_wr_data(f0_wr_data), .f1_wr_data(f1_wr_data),
        .f0_rd_en(f0_rd_en), .f1_rd_en(f1_rd_en),
        .f0_rd_data(f0_rd_data), .f1_rd_data(f1_rd_data),
        .f0_empty(f0_empty), .f1_empty(f1_empty),
        .f0_full(f0_full), .f1_full(f1_full),
        .win_valid(win_valid), .win_data(win_data),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural show-ahead FIFOs, depth 16, reset by the same rst_n.
    logic [DW-1:0] m0 [16];
    logic [DW-1:0] m1 [16];
    logic [3:0] w0, r0, w1, r1;
    logic [4:0] n0, n1;
    logic frc_f0 = 1'b0, frc_e0 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0 <= 0; r0 <= 0; n0 <= 0;
            w1 <= 0; r1 <= 0; n1 <= 0;
        end else begin
            if (f0_wr_en) begin m0[w0] <= f0_wr_data; w0 <= w0 + 4'd1; end
            if (f0_rd_en) r0 <= r0 + 4'd1;
            n0 <= n0 + 5'(f0_wr_en) - 5'(f0_rd_en);
            if (f1_wr_en) begin m1[w1] <= f1_wr_data; w1 <= w1 + 4'd1; end
            if (f1_rd_en) r1 <= r1 + 4'd1;
            n1 <= n1 + 5'(f1_wr_en) - 5'(f1_rd_en);
        end
    end

    assign f0_rd_data = m0[r0];
    assign f1_rd_data = m1[r1];
    assign f0_empty   = (n0 == 5'd0) || frc_e0;
    assign f1_empty   = (n1 == 5'd0);
    assign f0_full    = (n0 == 5'd16) || frc_f0;
    assign f1_full    = (n1 == 5'd16);

    typedef struct {
        logic [9*DW-1:0] win;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;

    // Window for the pixel at (r,c): rows r-2..r, columns c-2..c of pixel = row*16+col.
    function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[(rr*3+cc)*DW +: DW] = 8'((r - 2 + rr) * 16 + (c - 2 + cc));
        return w;
    endfunction

    // Scoreboard: every win_valid pulse must match the oldest queued window and cycle.
    always @(negedge clk) begin
        if (rst_n && win_valid) begin
            exp_t e;
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL win_unexpected: pulse at cycle %0d, data %h, none required", cyc, win_data);
            end else begin
                e = exp_q.pop_front();
                if (win_data !== e.win || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL win_data: got %h at cycle %0d, required %h at cycle %0d",
                             win_data, cyc, e.win, e.cyc);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        in_valid = 1'b0;
        frc_f0 = 1'b0;
        frc_e0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one 4x4 frame then watches the drain, returning pop counts and timing.
    task automatic drive_frame(input bit gap, input bit inj, output int d0, output int d1,
                               output int t_empty, output int t_idle);
        pulse_cnt = 0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap && !(r == 0 && c == 0)) @(negedge clk);
                in_valid = 1'b1;
                in_data  = 8'(r * 16 + c);
                if (inj && r == 2 && c == 1) frame_start = 1'b1;
                if (r >= 2 && c >= 2) exp_q.push_back('{exp_win(r, c), cyc + 1});
                @(negedge clk);
                in_valid = 1'b0;
                frame_start = 1'b0;
            end
        end
        d0 = 0; d1 = 0; t_empty = -1; t_idle = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busy) begin t_idle = i; break; end
            if (f0_rd_en) d0++;
            if (f1_rd_en) d1++;
            if (t_empty < 0 && f0_empty && f1_empty) t_empty = i;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, win_valid, err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: busy/win_valid/err %b, required 0000", {busy, win_valid, err});
        end
        checks++;
        if (win_data !== '0) begin
            errors++; $display("FAIL reset_win: %h, required 0", win_data);
        end
        checks++;
        if ({f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_en: %b, required 0000", {f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame(input string name, input bit gap, input bit inj);
        int d0, d1, te, ti;
        drive_frame(gap, inj, d0, d1, te, ti);
        checks++;
        if (pulse_cnt !== 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL %s_pulses: %0d pulses, %0d missing, required 4 and 0", name, pulse_cnt, exp_q.size());
        end
        checks++;
        if (d0 !== 4 || d1 !== 4) begin
            errors++; $display("FAIL %s_drain: pops f0=%0d f1=%0d, required 4 and 4", name, d0, d1);
        end
        checks++;
        if (te !== 4 || ti !== 5) begin
            errors++; $display("FAIL %s_busy: empty at %0d idle at %0d, required 4 and 5", name, te, ti);
        end
        checks++;
        if (err !== (inj ? 2'b10 : 2'b00)) begin
            errors++; $display("FAIL %s_err: %b, required %b", name, err, inj ? 2'b10 : 2'b00);
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        frc_f0 = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h3C;
        #1;
        checks++;
        if (f0_wr_en !== 1'b0) begin
            errors++; $display("FAIL ovf_wr_en: %b, required 0", f0_wr_en);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (err !== 2'b01) begin
            errors++; $display("FAIL ovf_err: %b, required 01", err);
        end
        do_reset();
    endtask

    task automatic test_underflow();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int c = 0; c < W; c++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h40 + c);
            @(negedge clk);
        end
        frc_e0 = 1'b1;
        in_data = 8'hA5;
        #1;
        checks++;
        if (f0_rd_en !== 1'b0) begin
            errors++; $display("FAIL udf_rd_en: %b, required 0", f0_rd_en);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (err !== 2'b10) begin
            errors++; $display("FAIL udf_err: %b, required 10", err);
        end
        checks++;
        if (win_data[5*DW +: DW] !== 8'h00 || win_data[8*DW +: DW] !== 8'hA5) begin
            errors++; $display("FAIL udf_tap: row1 %h row2 %h, required 00 and a5",
                               win_data[5*DW +: DW], win_data[8*DW +: DW]);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_stream();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int p = 0; p < 2 * W + 2; p++) begin
            in_valid = 1'b1;
            in_data = 8'((p / W) * 16 + (p % W));
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy_before: %b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, win_valid, err} !== 4'b0000 || win_data !== '0) begin
            errors++; $display("FAIL mid_reset_out: busy/vld/err %b win %h, required all 0",
                               {busy, win_valid, err}, win_data);
        end
        checks++;
        if ({f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_en: %b, required 0000", {f0_wr_en, f1_wr_en, f0_rd_en, f1_rd_en});
        end
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        test_frame("after_reset", 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        test_reset();
        test_frame("back_to_back", 1'b0, 1'b0);
        test_frame("gapped", 1'b1, 1'b0);
        test_frame("fs_in_stream", 1'b0, 1'b1);
        test_overflow();
        test_underflow();
        test_reset_mid_stream();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
